serial_frame_receiver: RTL and testbench

//  Receive end of the Sender serial link: recovers 10-bit-time frames (start 0, DATA_W data

---
 rtl/link_pkg.sv | 17 +
 rtl/serial_frame_receiver_bit_sync.sv | 29 ++
 rtl/serial_frame_receiver.sv | 134 +++++++++++++
 tb/tb_serial_frame_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared link definitions: frame geometry and receiver state encoding,
// common to the Sender frame generator and the Receiver.
package link_pkg;

    localparam int LINK_DATA_W    = 8;
    localparam int LINK_OVS       = 4;
    localparam int LINK_FRAME_LEN = LINK_DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA_ST,
        STOP,
        BREAK
    } link_state_e;

endpackage

// File: rtl/serial_frame_receiver_bit_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module bit_sync (
    input  logic C,
    input  logic CLR,
    input  logic D,
    output logic Q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = D;
        sync_d = meta_q;
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign Q = sync_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start/data/stop framing recovered from oversampled line D,
// byte presented on DATA with one-cycle VALID, framing errors flagged on FERR.
module serial_frame_receiver
    import link_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W,
    parameter int OVS    = LINK_OVS
) (
    input  logic              C,
    input  logic              CLR,
    input  logic              CE,
    input  logic              D,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    output logic              FERR,
    output logic              BUSY
);

    localparam int TICK_W = $clog2(OVS);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    link_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ds;

    bit_sync u_sync (
        .C   (C),
        .CLR (CLR),
        .D   (D),
        .Q   (ds)
    );

    // Strobes default low every cycle, so they last one C cycle even with CE held high.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (CE) begin
            unique case (state_q)
                IDLE: begin
                    if (!ds) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = ds ? IDLE : DATA_ST;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA_ST: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = {ds, shreg_q[DATA_W-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (ds) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    // A line stuck low must go high before a new start edge is accepted.
                    if (ds) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: directed and random frames
// compared against a frame-level reference model of the link.
module tb_serial_frame_receiver;

    localparam int DATA_W = 8;
    localparam int OVS    = 4;
    localparam int BIT_C  = 2 * OVS;

    logic              C = 1'b0;
    logic              CLR;
    logic              CE;
    logic              D;
    logic [DATA_W-1:0] DATA;
    logic              VALID;
    logic              FERR;
    logic              BUSY;

    logic ce_en    = 1'b1;
    logic ce_phase = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_data = '0;
    int   exp_ferr     = 0;
    int   valid_cycles = 0;
    int   valid_pulses = 0;
    int   ferr_cycles  = 0;
    int   ferr_pulses  = 0;
    int   both_high    = 0;
    logic prev_valid   = 1'b0;
    logic prev_ferr    = 1'b0;
    logic busy_mid     = 1'b0;

    serial_frame_receiver #(
        .DATA_W (DATA_W),
        .OVS    (OVS)
    ) u_dut (
        .C     (C),
        .CLR   (CLR),
        .CE    (CE),
        .D     (D),
        .DATA  (DATA),
        .VALID (VALID),
        .FERR  (FERR),
        .BUSY  (BUSY)
    );

    always #5 C = ~C;

    always @(posedge C) ce_phase <= ~ce_phase;
    assign CE = ce_en & ce_phase;

    // Output monitor: collects delivered bytes and strobe statistics.
    always @(negedge C) begin
        if (!CLR) begin
            if (VALID) begin
                got_q.push_back(DATA);
                valid_cycles++;
                if (!prev_valid) valid_pulses++;
            end
            if (FERR) begin
                ferr_cycles++;
                if (!prev_ferr) ferr_pulses++;
            end
            if (VALID && FERR) both_high++;
        end
        prev_valid = VALID;
        prev_ferr  = FERR;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bit(input logic b);
        D = b;
        repeat (BIT_C) @(negedge C);
    endtask

    task automatic idle_bits(input int n);
        D = 1'b1;
        repeat (n * BIT_C) @(negedge C);
    endtask

    // Sends one complete frame and updates the reference model.
    task automatic apply_stimulus(input logic [DATA_W-1:0] b, input logic stop_bit);
        drive_bit(1'b0);
        busy_mid = BUSY;
        for (int i = 0; i < DATA_W; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_data = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_frames(input string tag);
        int n;
        check_output({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_output({tag, "_data"}, 32'(DATA), 32'(exp_data));
        check_output({tag, "_ferr"}, ferr_pulses, exp_ferr);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] pb;
        logic [DATA_W-1:0] rb;
        int gap;

        CLR = 1'b1;
        D   = 1'b1;
        repeat (4) @(negedge C);
        check_output("rst_data",  32'(DATA), 32'h0);
        check_output("rst_valid", 32'(VALID), 32'h0);
        check_output("rst_ferr",  32'(FERR), 32'h0);
        check_output("rst_busy",  32'(BUSY), 32'h0);
        CLR = 1'b0;
        idle_bits(2);

        $display("[TB] clean frame 0xA5");
        apply_stimulus(8'hA5, 1'b1);
        check_output("t1_busy_mid", 32'(busy_mid), 32'h1);
        idle_bits(2);
        check_output("t1_busy_after", 32'(BUSY), 32'h0);
        check_frames("t1");

        $display("[TB] glitch shorter than half a bit");
        D = 1'b0;
        repeat (2) @(negedge C);
        idle_bits(3);
        check_output("t2_busy", 32'(BUSY), 32'h0);
        check_frames("t2");

        $display("[TB] framing error then break");
        apply_stimulus(8'h3C, 1'b0);
        repeat (3 * BIT_C) @(negedge C);
        check_output("t3_busy_break", 32'(BUSY), 32'h1);
        idle_bits(2);
        check_output("t3_busy_idle", 32'(BUSY), 32'h0);
        check_frames("t3a");
        apply_stimulus(8'h11, 1'b1);
        idle_bits(2);
        check_frames("t3b");

        $display("[TB] reset during data bit 3");
        pb = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(pb[i]);
        D = pb[3];
        repeat (BIT_C / 2) @(negedge C);
        #2 CLR = 1'b1;
        #1;
        check_output("t4_clr_data",  32'(DATA), 32'h0);
        check_output("t4_clr_valid", 32'(VALID), 32'h0);
        check_output("t4_clr_ferr",  32'(FERR), 32'h0);
        check_output("t4_clr_busy",  32'(BUSY), 32'h0);
        D = 1'b1;
        repeat (3) @(negedge C);
        CLR = 1'b0;
        exp_data = '0;
        idle_bits(12);
        check_frames("t4a");
        apply_stimulus(8'h5A, 1'b1);
        idle_bits(2);
        check_frames("t4b");

        $display("[TB] back-to-back frames");
        apply_stimulus(8'h00, 1'b1);
        apply_stimulus(8'hFF, 1'b1);
        idle_bits(2);
        check_frames("t5");

        $display("[TB] clock enable stall mid-frame");
        pb = 8'h6B;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(pb[i]);
        D = pb[3];
        repeat (BIT_C / 2) @(negedge C);
        ce_en = 1'b0;
        repeat (20) @(negedge C);
        check_output("t6_busy_frozen", 32'(BUSY), 32'h1);
        ce_en = 1'b1;
        repeat (BIT_C / 2) @(negedge C);
        for (int i = 4; i < DATA_W; i++) drive_bit(pb[i]);
        drive_bit(1'b1);
        exp_q.push_back(pb);
        exp_data = pb;
        idle_bits(2);
        check_frames("t6");

        $display("[TB] random frames");
        for (int k = 0; k < 8; k++) begin
            rb  = DATA_W'($urandom);
            gap = $urandom_range(0, 2);
            apply_stimulus(rb, 1'b1);
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(2);
        check_frames("rand");

        check_output("valid_one_cycle", valid_cycles, valid_pulses);
        check_output("ferr_one_cycle",  ferr_cycles, ferr_pulses);
        check_output("never_both",      both_high, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
